// File: rtl/sd_fifo_pkg.sv
// Shared helpers for the sd_fifo family: width derivation and parameter checks.
`ifndef SD_FIFO_PKG_SV
`define SD_FIFO_PKG_SV

// Elaboration fails with a message when the parameter set is unusable.
`define SD_FIFO_ELAB_CHECK(cond, msg) \
    if (!(cond)) begin : g_elab_check_failed \
        $error(msg); \
    end

package sd_fifo_pkg;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result = 0;
        for (int unsigned p = 1; p < value; p = p << 1) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Pointers carry one extra lap bit above the memory index.
    function automatic int unsigned ptr_w(input int unsigned depth);
        return clog2(depth) + 1;
    endfunction

    function automatic bit is_pow2(input int unsigned value);
        return (value != 0) && ((value & (value - 1)) == 0);
    endfunction

endpackage

`endif

// File: rtl/sd_fifo_ram.sv
// DEPTH x DATA_W storage: synchronous write, asynchronous read; vendor-RAM swap point.
module sd_fifo_ram
    import sd_fifo_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    localparam int AW    = clog2(DEPTH)
)(
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] d,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= d;
        end
    end

    assign q = mem[raddr];

endmodule

// File: rtl/sd_fifo_sc.sv
// Single-clock FWFT FIFO with fill level, thresholds, flush and sticky error flags.
module sd_fifo_sc
    import sd_fifo_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    localparam int AW      = clog2(DEPTH)
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              wr,
    input  logic [DATA_W-1:0] d,
    input  logic              rd,
    output logic [DATA_W-1:0] q,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [AW:0]       level,
    output logic              overflow,
    output logic              underflow,
    input  logic              clr_err
);

    localparam int PW = ptr_w(DEPTH);
    localparam logic [AW:0] AF_TH = AF_LEVEL[AW:0];
    localparam logic [AW:0] AE_TH = AE_LEVEL[AW:0];

    `SD_FIFO_ELAB_CHECK(is_pow2(DEPTH) && DEPTH >= 4 && AE_LEVEL < AF_LEVEL && AF_LEVEL <= DEPTH,
                        "sd_fifo_sc: DEPTH must be a power of 2 >= 4 and AE_LEVEL < AF_LEVEL <= DEPTH")

    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic          we;
    logic          re;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
    assign level = wptr - rptr;

    assign almost_full  = (level >= AF_TH);
    assign almost_empty = (level <= AE_TH);

    // Flush masks the RAM write so a flushed cycle leaves memory untouched.
    assign we = wr & ~full & ~flush;
    assign re = rd & ~empty & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr      <= '0;
            rptr      <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            wptr      <= '0;
            rptr      <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (we) begin
                wptr <= wptr + 1'b1;
            end
            if (re) begin
                rptr <= rptr + 1'b1;
            end
            // A new error event wins over clr_err in the same cycle.
            if (wr && full) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (rd && empty) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

    sd_fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (wptr[AW-1:0]),
        .d     (d),
        .raddr (rptr[AW-1:0]),
        .q     (q)
    );

endmodule

// File: tb/tb_sd_fifo_sc.sv
// Scoreboard bench for sd_fifo_sc against a queue-based reference model.
module tb_sd_fifo_sc;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
    localparam int AF     = 14;
    localparam int AE     = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              flush = 1'b0;
    logic              wr = 1'b0;
    logic [DATA_W-1:0] d = '0;
    logic              rd = 1'b0;
    logic [DATA_W-1:0] q;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [4:0]        level;
    logic              overflow;
    logic              underflow;
    logic              clr_err = 1'b0;

    sd_fifo_sc #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .AF_LEVEL (AF),
        .AE_LEVEL (AE)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .wr           (wr),
        .d            (d),
        .rd           (rd),
        .q            (q),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .level        (level),
        .overflow     (overflow),
        .underflow    (underflow),
        .clr_err      (clr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int lvl;
        bit ovf;
        bit unf;
    } snap_t;

    snap_t             st_q[$];
    logic [DATA_W-1:0] exp_rd[$];

    // Reference model: stored words plus the two sticky flags.
    logic [DATA_W-1:0] mq[$];
    bit                m_ovf = 1'b0;
    bit                m_unf = 1'b0;
    logic [DATA_W-1:0] seq_data = 32'h100;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; called 1 time unit after a rising edge.
    task automatic step(input bit w, input bit r, input logic [DATA_W-1:0] dd,
                        input bit fl, input bit ce);
        snap_t s;
        bit    f;
        bit    e;
        s.lvl = mq.size();
        s.ovf = m_ovf;
        s.unf = m_unf;
        st_q.push_back(s);
        wr = w; rd = r; d = dd; flush = fl; clr_err = ce;
        if (fl) begin
            mq.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            f = (mq.size() == DEPTH);
            e = (mq.size() == 0);
            if (w && f) m_ovf = 1'b1;
            else if (ce) m_ovf = 1'b0;
            if (r && e) m_unf = 1'b1;
            else if (ce) m_unf = 1'b0;
            if (r && !e) begin
                exp_rd.push_back(mq[0]);
                void'(mq.pop_front());
            end
            if (w && !f) mq.push_back(dd);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic fill_to(input int n);
        while (mq.size() < n) begin
            step(1'b1, 1'b0, seq_data, 1'b0, 1'b0);
            seq_data++;
        end
    endtask

    task automatic drain();
        while (mq.size() > 0) step(1'b0, 1'b1, '0, 1'b0, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_empty"}, 64'(empty), 64'd1);
        check({tag, "_full"}, 64'(full), 64'd0);
        check({tag, "_level"}, 64'(level), 64'd0);
        check({tag, "_ae"}, 64'(almost_empty), 64'd1);
        check({tag, "_af"}, 64'(almost_full), 64'd0);
        check({tag, "_ovf"}, 64'(overflow), 64'd0);
        check({tag, "_unf"}, 64'(underflow), 64'd0);
    endtask

    // Monitor: mid-cycle, compare flags with the snapshot and q on every pop.
    always @(negedge clk) begin
        snap_t s;
        if (rst_n && st_q.size() > 0) begin
            s = st_q.pop_front();
            check("level", 64'(level), 64'(s.lvl));
            check("empty", 64'(empty), 64'(s.lvl == 0));
            check("full", 64'(full), 64'(s.lvl == DEPTH));
            check("almost_full", 64'(almost_full), 64'(s.lvl >= AF));
            check("almost_empty", 64'(almost_empty), 64'(s.lvl <= AE));
            check("overflow", 64'(overflow), 64'(s.ovf));
            check("underflow", 64'(underflow), 64'(s.unf));
            if (rd && !flush && !empty) begin
                if (exp_rd.size() == 0) begin
                    check("read_unexpected", 64'(1), 64'(0));
                end else begin
                    check("q", 64'(q), 64'(exp_rd.pop_front()));
                end
            end
        end
    end

    initial begin
        #2;
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Fill to full, overflow on the 17th write, then read the head.
        fill_to(DEPTH);
        step(1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0);
        step(1'b0, 1'b1, '0, 1'b0, 1'b0);
        drain();
        step(1'b0, 1'b0, '0, 1'b0, 1'b1);

        // Interleaved traffic with incrementing data across the lap-bit wrap.
        for (int i = 0; i < 40; i++) begin
            step(($urandom % 4) != 0, ($urandom % 2) == 1, seq_data, 1'b0, 1'b0);
            seq_data++;
        end
        drain();
        idle();

        // Simultaneous wr/rd while empty, then clr_err while popping.
        step(1'b1, 1'b1, 32'hA5A5_A5A5, 1'b0, 1'b0);
        step(1'b0, 1'b1, '0, 1'b0, 1'b1);
        idle();

        // Simultaneous wr/rd while full: head pops, write data lost.
        fill_to(DEPTH);
        step(1'b1, 1'b1, 32'hBAD0_0001, 1'b0, 1'b0);
        drain();
        step(1'b0, 1'b0, '0, 1'b0, 1'b1);

        // Flush at level 9 with errors pending and wr/rd asserted.
        step(1'b0, 1'b1, '0, 1'b0, 1'b0);
        fill_to(DEPTH);
        step(1'b1, 1'b0, 32'hBAD0_0002, 1'b0, 1'b0);
        while (mq.size() > 9) step(1'b0, 1'b1, '0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'hBAD0_0003, 1'b1, 1'b1);
        idle();

        // Randomised traffic with occasional flush and clr_err.
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 3) != 0, ($urandom % 3) != 0, $urandom,
                 ($urandom % 50) == 0, ($urandom % 20) == 0);
        end
        drain();
        idle();

        // Asynchronous reset mid-burst at level 7.
        fill_to(7);
        step(1'b0, 1'b1, '0, 1'b0, 1'b0);
        step(1'b1, 1'b0, seq_data, 1'b0, 1'b0);
        seq_data++;
        step(1'b0, 1'b1, '0, 1'b0, 1'b0);
        step(1'b0, 1'b1, '0, 1'b0, 1'b0);
        fill_to(7);
        wr = 1'b1; rd = 1'b0; flush = 1'b0; clr_err = 1'b0; d = 32'hBAD0_0004;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        wr = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mq.delete();
        exp_rd.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        fill_to(5);
        drain();
        idle();
        idle();

        check("scoreboard_drained", 64'(exp_rd.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sd_fifo_sc.md
Name: sd_fifo_sc

Overview:
- Parametrised single-clock FIFO for the SD DMA data path; next generation of the fixed 32x16 TX FIFO.
- Configurable data width and power-of-2 depth; full-width fill level; programmable almost-full and almost-empty thresholds.
- Adds synchronous flush and sticky overflow/underflow error flags.
- Sits between the Wishbone DMA master and the SD data serialiser (TX), or between the deserialiser and the DMA (RX).

Parameters:
- DATA_W, 32, data word width in bits.
- DEPTH, 16, number of entries; must be a power of 2, minimum 4.
- AF_LEVEL, DEPTH-2, almost_full asserts when level >= AF_LEVEL.
- AE_LEVEL, 2, almost_empty asserts when level <= AE_LEVEL.
- Derived constant AW = clog2(DEPTH); pointers and level are AW+1 bits.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- flush  in  1  synchronous clear of pointers and error flags.
- wr  in  1  write request.
- d  in  DATA_W  write data.
- rd  in  1  read request; pops the current head word.
- q  out  DATA_W  head word, first-word-fall-through.
- full  out  1  DEPTH words stored.
- empty  out  1  no words stored.
- almost_full  out  1  level >= AF_LEVEL.
- almost_empty  out  1  level <= AE_LEVEL.
- level  out  AW+1  words stored, range 0..DEPTH.
- overflow  out  1  sticky; set by a write attempted while full.
- underflow  out  1  sticky; set by a read attempted while empty.
- clr_err  in  1  clears overflow and underflow.

Behaviour:
- Reset (rst_n low, asynchronous):
  - wptr, rptr, overflow and underflow all go to 0.
  - Resulting outputs: empty=1, full=0, level=0, almost_empty=1, almost_full=0.
  - Reset mid-operation discards all contents. Memory array is not reset.
- Pointers are AW+1 bits and advance by 1, wrapping naturally. The MSB is the lap bit; bits [AW-1:0] index memory.
- Flags:
  - empty = (wptr == rptr).
  - full = (lower AW bits equal) and (MSBs differ).
  - level = wptr - rptr, modulo 2^(AW+1).
- Accept rules, evaluated on current-cycle flags:
  - we = wr & ~full.
  - re = rd & ~empty.
  - wr while full: write dropped, memory and wptr unchanged, overflow<=1.
  - rd while empty: no pointer change, underflow<=1.
  - wr & rd while full: read accepted, write rejected, overflow set. Level drops to DEPTH-1.
  - wr & rd while empty: write accepted, read rejected, underflow set. Level becomes 1.
  - wr & rd otherwise: both accepted, level unchanged.
- Write: on we, mem[wptr[AW-1:0]] <= d and wptr <= wptr+1. Data is visible on q the next cycle if the FIFO was empty, so write-to-read latency is 1 cycle.
- Read: q = mem[rptr[AW-1:0]] combinationally. On re, rptr <= rptr+1 and q shows the next word in the same cycle the pointer updates. q is don't-care while empty.
- Flush:
  - Sets wptr=rptr=0 and clears overflow and underflow.
  - Has priority over wr, rd and clr_err in the same cycle; no error flag is set that cycle.
- clr_err: clears both sticky flags. If an error event occurs in the same cycle, the flag is set, because set wins over clear.
- Thresholds: almost_full and almost_empty are combinational from level, with unsigned compares at AW+1 bits.
- All flags and level are combinational from registered pointers. There is no path from wr/rd to any output other than through registers.
- Elaboration check: DEPTH must be a power of 2, and AE_LEVEL < AF_LEVEL <= DEPTH; otherwise elaboration fails.

Decomposition:
- Package sd_fifo_pkg holds:
  - function clog2;
  - the pointer-width derivation;
  - the elaboration-check macro.
- Sub-module sd_fifo_ram: DEPTH x DATA_W dual-port memory with synchronous write and asynchronous read, so it can be swapped for a vendor RAM.
- Top level holds the pointers, flags, error flags and flush logic.

Test Plan (DATA_W=32, DEPTH=16, AF=14, AE=2):
- Reset then write 16 words 0x100..0x10F:
  - full=1 after the 16th write, level=16, almost_full from level 14.
  - 17th write sets overflow=1, level stays 16, and a subsequent read returns 0x100.
- Fill/drain wrap:
  - 40 interleaved writes and reads of incrementing data.
  - q sequence must match a model exactly across the pointer MSB wrap.
  - empty=1 at the end, level=0.
- Empty then wr=1 rd=1 with d=0xA5A5A5A5:
  - next cycle level=1, q=0xA5A5A5A5, underflow=1.
  - clr_err next cycle clears underflow.
- Full with wr & rd same cycle: level 16->15, overflow=1, head word popped, write data lost.
- Level 9 with flush=1, wr=1, rd=1: next cycle level=0, empty=1, overflow=0 and underflow=0.
- Assert rst_n low asynchronously mid-burst at level 7: flags go to reset values before the next clock edge, and writes resume correctly after release.
